// File: rtl/rng_share_arbiter.sv
// Shares one taus113 generator among NUM_REQ consumers: round-robin grants of one
// word per cycle, plus a reseed sequencer that blocks grants until the new seed settles.
module rng_share_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [31:0]        rnd_out,
    output logic               rnd_valid,
    input  logic               reseed_req,
    input  logic [31:0]        reseed_seed,
    output logic               reseed_ack,
    output logic               reseed_busy,
    output logic [15:0]        words_issued,
    output logic [31:0]        gen_seed,
    output logic               gen_re_seed,
    input  logic [31:0]        gen_rnd
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        SERVE,
        RESEED,
        SETTLE
    } state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [CW-1:0]     settle_cnt;

    logic              win_found;
    logic [PW-1:0]     win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    int unsigned       cand;

    // Scan starts one past the last winner so the previous winner has lowest priority.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        cand       = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req[PW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
        win_onehot[win_idx] = win_found;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SERVE;
            ptr          <= PW'(NUM_REQ - 1);
            settle_cnt   <= '0;
            gnt          <= '0;
            rnd_out      <= '0;
            rnd_valid    <= 1'b0;
            reseed_ack   <= 1'b0;
            reseed_busy  <= 1'b0;
            words_issued <= '0;
            gen_seed     <= '0;
            gen_re_seed  <= 1'b0;
        end else begin
            gnt         <= '0;
            rnd_valid   <= 1'b0;
            reseed_ack  <= 1'b0;
            gen_re_seed <= 1'b0;
            case (state)
                SERVE: begin
                    if (reseed_req) begin
                        gen_seed     <= reseed_seed;
                        gen_re_seed  <= 1'b1;
                        reseed_ack   <= 1'b1;
                        reseed_busy  <= 1'b1;
                        words_issued <= '0;
                        state        <= RESEED;
                    end else if (win_found) begin
                        gnt          <= win_onehot;
                        rnd_out      <= gen_rnd;
                        rnd_valid    <= 1'b1;
                        ptr          <= win_idx;
                        words_issued <= words_issued + 16'd1;
                    end
                end
                RESEED: begin
                    settle_cnt <= CW'(SETTLE_CYCLES);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt <= CW'(1)) begin
                        settle_cnt  <= '0;
                        reseed_busy <= 1'b0;
                        state       <= SERVE;
                    end else begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end
                end
                default: state <= SERVE;
            endcase
        end
    end

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Scoreboard bench for rng_share_arbiter; a behavioural xorshift stand-in plays the
// generator so every expected word is known when the request is issued.
module tb_rng_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [31:0] rnd_out;
    logic        rnd_valid;
    logic        reseed_req;
    logic [31:0] reseed_seed;
    logic        reseed_ack;
    logic        reseed_busy;
    logic [15:0] words_issued;
    logic [31:0] gen_seed;
    logic        gen_re_seed;
    logic [31:0] gen_rnd;

    rng_share_arbiter #(
        .NUM_REQ      (4),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .gnt         (gnt),
        .rnd_out     (rnd_out),
        .rnd_valid   (rnd_valid),
        .reseed_req  (reseed_req),
        .reseed_seed (reseed_seed),
        .reseed_ack  (reseed_ack),
        .reseed_busy (reseed_busy),
        .words_issued(words_issued),
        .gen_seed    (gen_seed),
        .gen_re_seed (gen_re_seed),
        .gen_rnd     (gen_rnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    // Generator stand-in: advances every edge, loads the seed when re_seed is sampled.
    logic [31:0] g = 32'h2545_F491;
    always @(posedge clk) g <= gen_re_seed ? gen_seed : xs(g);
    assign gen_rnd = g;

    typedef struct {
        logic [3:0]  g;
        logic [31:0] w;
        logic [15:0] n;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_cnt = '0;
    logic [31:0] last_w  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per presented grant.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (gnt != 4'b0000) begin
                chk("rnd_valid_on_gnt", {31'b0, rnd_valid}, 32'd1);
                if (sb.size() == 0) begin
                    chk("unexpected_gnt", {28'b0, gnt}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("gnt", {28'b0, gnt}, {28'b0, e.g});
                    chk("rnd_out", rnd_out, e.w);
                    chk("words_issued", {16'b0, words_issued}, {16'b0, e.n});
                end
            end else begin
                chk("rnd_valid_idle", {31'b0, rnd_valid}, 32'd0);
            end
        end
    end

    // Drive one cycle of inputs; acc marks a reseed the DUT must accept, eg the expected grant.
    task automatic step(input logic [3:0] r, input logic rs, input logic [31:0] sd,
                        input logic acc, input logic [3:0] eg);
        exp_t e;
        @(negedge clk);
        req         = r;
        reseed_req  = rs;
        reseed_seed = sd;
        if (acc) exp_cnt = '0;
        if (eg != 4'b0000) begin
            exp_cnt = exp_cnt + 16'd1;
            e.g = eg;
            e.w = g;
            e.n = exp_cnt;
            sb.push_back(e);
            last_w = g;
        end
        @(posedge clk);
        #1;
    endtask

    // Reseed sequence checks around acceptance and the settle window.
    task automatic reseed_seq(input logic [3:0] r, input logic [31:0] sd);
        step(r, 1'b1, sd, 1'b1, 4'b0000);
        chk("reseed_ack_pulse", {31'b0, reseed_ack}, 32'd1);
        chk("gen_re_seed_high", {31'b0, gen_re_seed}, 32'd1);
        chk("reseed_busy_set", {31'b0, reseed_busy}, 32'd1);
        chk("gen_seed_captured", gen_seed, sd);
        chk("words_cleared", {16'b0, words_issued}, 32'd0);
        step(r, 1'b0, 32'd0, 1'b0, 4'b0000);
        chk("gen_re_seed_drop", {31'b0, gen_re_seed}, 32'd0);
        chk("reseed_ack_drop", {31'b0, reseed_ack}, 32'd0);
        chk("busy_settle1", {31'b0, reseed_busy}, 32'd1);
        step(r, 1'b0, 32'd0, 1'b0, 4'b0000);
        chk("busy_settle2", {31'b0, reseed_busy}, 32'd1);
        step(r, 1'b0, 32'd0, 1'b0, 4'b0000);
        chk("busy_release", {31'b0, reseed_busy}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        req         = 4'b1111;
        reseed_req  = 1'b0;
        reseed_seed = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", {28'b0, gnt}, 32'd0);
        chk("rst_re_seed", {31'b0, gen_re_seed}, 32'd0);
        chk("rst_words", {16'b0, words_issued}, 32'd0);
        chk("rst_rnd_out", rnd_out, 32'd0);
        chk("rst_gen_seed", gen_seed, 32'd0);
        chk("rst_busy", {31'b0, reseed_busy}, 32'd0);
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;

        // Round-robin from reset: requester 0 first.
        step(4'b1111, 1'b0, 32'd0, 1'b0, 4'b0001);
        step(4'b1111, 1'b0, 32'd0, 1'b0, 4'b0010);
        step(4'b1111, 1'b0, 32'd0, 1'b0, 4'b0100);
        step(4'b1111, 1'b0, 32'd0, 1'b0, 4'b1000);
        step(4'b1111, 1'b0, 32'd0, 1'b0, 4'b0001);
        step(4'b0000, 1'b0, 32'd0, 1'b0, 4'b0000);
        step(4'b0000, 1'b0, 32'd0, 1'b0, 4'b0000);
        chk("idle_gnt", {28'b0, gnt}, 32'd0);
        chk("rnd_out_hold", rnd_out, last_w);

        // Reseed while requester 0 holds req.
        reseed_seq(4'b0001, 32'hDEAD_BEEF);
        step(4'b0001, 1'b0, 32'd0, 1'b0, 4'b0001);
        step(4'b0001, 1'b0, 32'd0, 1'b0, 4'b0001);
        step(4'b0001, 1'b0, 32'd0, 1'b0, 4'b0001);

        reseed_seq(4'b0001, 32'hCAFE_BABE);
        step(4'b0001, 1'b0, 32'd0, 1'b0, 4'b0001);
        step(4'b0001, 1'b0, 32'd0, 1'b0, 4'b0001);

        // Reseed beats a simultaneous request; a reseed during SETTLE is ignored.
        step(4'b0010, 1'b1, 32'h1357_9BDF, 1'b1, 4'b0000);
        chk("simul_ack", {31'b0, reseed_ack}, 32'd1);
        step(4'b0010, 1'b0, 32'd0, 1'b0, 4'b0000);
        step(4'b0010, 1'b1, 32'h1111_1111, 1'b0, 4'b0000);
        chk("settle_no_ack", {31'b0, reseed_ack}, 32'd0);
        chk("settle_seed_kept", gen_seed, 32'h1357_9BDF);
        step(4'b0010, 1'b0, 32'd0, 1'b0, 4'b0000);
        chk("settle_seed_kept2", gen_seed, 32'h1357_9BDF);
        step(4'b0010, 1'b0, 32'd0, 1'b0, 4'b0010);
        step(4'b0010, 1'b0, 32'd0, 1'b0, 4'b0010);

        // Fairness between requesters 1 and 3 (pointer currently at 1).
        for (int i = 0; i < 4; i++) begin
            step(4'b1010, 1'b0, 32'd0, 1'b0, 4'b1000);
            step(4'b1010, 1'b0, 32'd0, 1'b0, 4'b0010);
        end

        // Asynchronous reset in the middle of SETTLE.
        step(4'b0001, 1'b1, 32'h0BAD_F00D, 1'b1, 4'b0000);
        step(4'b0001, 1'b0, 32'd0, 1'b0, 4'b0000);
        step(4'b0001, 1'b0, 32'd0, 1'b0, 4'b0000);
        chk("pre_rst_busy", {31'b0, reseed_busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy", {31'b0, reseed_busy}, 32'd0);
        chk("async_gnt", {28'b0, gnt}, 32'd0);
        chk("async_re_seed", {31'b0, gen_re_seed}, 32'd0);
        chk("async_words", {16'b0, words_issued}, 32'd0);
        chk("async_seed", gen_seed, 32'd0);
        @(negedge clk);
        req     = 4'b0000;
        rst_n   = 1'b1;
        exp_cnt = '0;
        step(4'b1111, 1'b0, 32'd0, 1'b0, 4'b0001);
        step(4'b1111, 1'b0, 32'd0, 1'b0, 4'b0010);
        step(4'b0000, 1'b0, 32'd0, 1'b0, 4'b0000);
        step(4'b0000, 1'b0, 32'd0, 1'b0, 4'b0000);

        chk("sb_drain", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rng_share_arbiter.md
# rng_share_arbiter

Round-robin arbiter and reseed sequencer that shares one taus113 generator among NUM_REQ consumers. The generator advances one word per clock. This block hands each word to at most one requester, and it owns the generator's seed/re_seed inputs. It also blocks grants while a reseed is settling, so no consumer receives a pre-seed or transitional word. It sits between the taus113 instance and the stochastic-compute lanes.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..16.
- SETTLE_CYCLES, 2: cycles after the re_seed pulse before the generator's output reflects the new seed.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req  in  NUM_REQ  level request, one bit per consumer.
- gnt  out  NUM_REQ  registered one-hot grant pulse; rnd_out is valid in the same cycle.
- rnd_out  out  32  word delivered with gnt.
- rnd_valid  out  1  equals OR of gnt.
- reseed_req  in  1  single-cycle reseed request.
- reseed_seed  in  32  seed qualified by reseed_req.
- reseed_ack  out  1  one-cycle pulse when a reseed is accepted.
- reseed_busy  out  1  high from acceptance until grants may resume.
- words_issued  out  16  number of grants since the last accepted reseed or reset.
- gen_seed  out  32  drives the generator's seed input.
- gen_re_seed  out  1  drives the generator's re_seed input.
- gen_rnd  in  32  generator output.

## Operation
- States are SERVE, RESEED and SETTLE. Reset state is SERVE.
- Reset values: gnt=0, rnd_out=0, rnd_valid=0, reseed_ack=0, reseed_busy=0, words_issued=0, gen_seed=0, gen_re_seed=0. Round-robin pointer=NUM_REQ-1, so requester 0 has highest priority first.
- SERVE with reseed_req=1:
  - Capture reseed_seed into gen_seed.
  - Next cycle: gen_re_seed=1, reseed_ack=1, reseed_busy=1, words_issued cleared, go to RESEED.
  - No grant is issued for that cycle's req.
  - Reseed wins over simultaneous req.
- SERVE with reseed_req=0 and req!=0:
  - Pick the first set req bit after the pointer, wrapping modulo NUM_REQ.
  - Next cycle: gnt=onehot(winner), rnd_out=gen_rnd sampled at that edge, rnd_valid=1.
  - Pointer becomes the winner; words_issued increments, wrapping 0xFFFF→0x0000.
- SERVE with req=0: gnt=0, and rnd_out holds its last value.
- RESEED lasts exactly one cycle, then goes to SETTLE with the counter loaded to SETTLE_CYCLES.
- SETTLE:
  - The counter decrements each cycle.
  - When the counter reaches 1, the next state is SERVE and reseed_busy deasserts on entry to SERVE.
  - gen_re_seed=0 throughout SETTLE.
- reseed_req is ignored (no ack) in RESEED and SETTLE. req is ignored in RESEED and SETTLE, and the pointer is unchanged.
- gen_seed holds the last accepted seed indefinitely.
- A requester holding req high receives repeated grants, interleaved round-robin with other active requesters. With only one requester active, it receives a grant every cycle.

## Timing
- Grant latency: req sampled at edge N gives gnt/rnd_out valid between edges N and N+1. At most one grant per cycle.
- Each generator word goes to at most one requester, because the generator advances every cycle and at most one grant is issued per cycle.
- Reseed sequence, with reseed_req sampled at edge R:
  - gen_re_seed is high for the single cycle R..R+1.
  - SETTLE occupies the SETTLE_CYCLES cycles that follow.
  - The first grantable sample is at edge R+2+SETTLE_CYCLES, and it carries the generator's first post-seed word.
  - reseed_busy is high for 1+SETTLE_CYCLES cycles, and gnt=0 throughout that window.
- rst_n asserted mid-operation (any state, including mid-SETTLE) immediately forces all outputs to their reset values. An in-flight reseed is abandoned, and gen_re_seed drops asynchronously.

## Test plan
- Reset: hold rst_n=0 with req=4'b1111 → gnt=0, gen_re_seed=0, words_issued=0. After release, grants go 0,1,2,3,0 on consecutive cycles.
- Reseed with 0xDEADBEEF while requester 0 holds req:
  - gen_re_seed is a 1-cycle pulse, gen_seed=0xDEADBEEF, reseed_ack is a 1-cycle pulse.
  - No grant for 3 cycles.
  - Then rnd_out=3091505929, 2837792084, 222548152 on consecutive grants, with words_issued=1,2,3.
- Reseed with 0xCAFEBABE after the above: the first two granted words are 2852563200 and 2164347728, and words_issued restarts at 1.
- Simultaneous reseed_req and req=4'b0010 in SERVE → no grant for that req, reseed accepted. A second reseed_req during SETTLE → no reseed_ack, and gen_seed is unchanged.
- Fairness: req=4'b1010 held for 8 cycles → gnt alternates 4'b0010 and 4'b1000, 4 grants each, and rnd_out never repeats a generator word.
- Assert rst_n=0 during SETTLE → reseed_busy=0 and gnt=0 immediately. After release, grants resume with requester 0 first.
